// File: rtl/inport_pkg.sv
// inport_pkg: shared types, constants and byte extension helper for the input-port loader
package inport_pkg;
   typedef enum logic {IDLE, COLLECT} state_t;
   localparam int BYTES_PER_WORD = 4;
   localparam int SYNC_STAGES = 2;
   function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sx);
      return {{24{sx & b[7]}}, b};
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a bouncy button, debounces it and emits a registered rising-edge pulse
module btn_debounce
   import inport_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_rise
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_level;
   logic                   r_level_q;
   logic                   r_rise;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync    <= '0;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_level_q <= 1'b0;
         r_rise    <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], i_btn};
         r_level_q <= r_level;
         r_rise    <= r_level & ~r_level_q;
         if (r_sync[SYNC_STAGES-1] == r_level) r_cnt <= '0;
         else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
         end else r_cnt <= r_cnt + CW'(1);
      end
   end
   assign o_rise = r_rise;
endmodule

// File: rtl/inport_loader.sv
// inport_loader: captures slide-switch bytes on debounced button presses and publishes bytes or assembled words
module inport_loader
   import inport_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SIGN_EXTEND     = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  sw_in,
   input  logic        load_btn,
   input  logic        word_mode,
   output logic [31:0] inport_data,
   output logic        inport_strobe,
   output logic [1:0]  byte_count,
   output logic        collecting
);
   localparam logic SX = (SIGN_EXTEND != 0);
   logic [SYNC_STAGES-1:0][7:0] r_sw_s;
   logic [SYNC_STAGES-1:0]      r_mode_s;
   logic                        r_mode_q;
   state_t                      r_state;
   logic [31:0]                 r_data;
   logic [23:0]                 r_stg;
   logic [1:0]                  r_cnt;
   logic                        r_strobe;
   state_t                      w_state_n;
   logic [31:0]                 w_data_n;
   logic [23:0]                 w_stg_n;
   logic [1:0]                  w_cnt_n;
   logic                        w_strobe_n;
   logic                        w_load;
   logic [7:0]                  w_byte;
   logic                        w_mode;
   logic                        w_mode_chg;
   logic                        w_last;
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset  (reset),
      .i_btn  (load_btn),
      .o_rise (w_load)
   );
   assign w_byte     = r_sw_s[SYNC_STAGES-1];
   assign w_mode     = r_mode_s[SYNC_STAGES-1];
   assign w_mode_chg = w_mode ^ r_mode_q;
   assign w_last     = r_cnt == 2'(BYTES_PER_WORD - 1);
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sw_s   <= '0;
         r_mode_s <= '0;
         r_mode_q <= 1'b0;
         r_state  <= IDLE;
         r_data   <= '0;
         r_stg    <= '0;
         r_cnt    <= '0;
         r_strobe <= 1'b0;
      end else begin
         r_sw_s   <= {r_sw_s[SYNC_STAGES-2:0], sw_in};
         r_mode_s <= {r_mode_s[SYNC_STAGES-2:0], word_mode};
         r_mode_q <= w_mode;
         r_state  <= w_state_n;
         r_data   <= w_data_n;
         r_stg    <= w_stg_n;
         r_cnt    <= w_cnt_n;
         r_strobe <= w_strobe_n;
      end
   end
   always_comb begin
      w_state_n = (r_state == IDLE) ? ((w_load && w_mode) ? COLLECT : IDLE)
                                    : ((w_mode_chg || (w_load && w_last)) ? IDLE : COLLECT);
   end
   // A mode change while collecting aborts the word and swallows any coincident load
   always_comb begin
      w_data_n   = r_data;
      w_stg_n    = r_stg;
      w_cnt_n    = r_cnt;
      w_strobe_n = 1'b0;
      if (r_state == IDLE) begin
         if (w_load && !w_mode) begin
            w_data_n   = extend_byte(w_byte, SX);
            w_strobe_n = 1'b1;
         end else if (w_load) begin
            w_stg_n = {16'b0, w_byte};
            w_cnt_n = 2'd1;
         end
      end else if (w_mode_chg) begin
         w_stg_n = '0;
         w_cnt_n = '0;
      end else if (w_load && w_last) begin
         w_data_n   = {r_stg, w_byte};
         w_strobe_n = 1'b1;
         w_stg_n    = '0;
         w_cnt_n    = '0;
      end else if (w_load) begin
         w_stg_n = {r_stg[15:0], w_byte};
         w_cnt_n = r_cnt + 2'd1;
      end
   end
   assign inport_data   = r_data;
   assign inport_strobe = r_strobe;
   assign byte_count    = r_cnt;
   assign collecting    = (r_state == COLLECT);
endmodule

// File: tb/tb_inport_loader.sv
// tb_inport_loader: randomized scoreboard bench running zero- and sign-extending loaders side by side
module tb_inport_loader;
   localparam int D = 4;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_btn = 1'b0;
   logic        word_mode = 1'b0;
   logic [7:0]  sw_in = 8'h00;
   logic [31:0] d0, d1;
   logic        s0, s1, c0, c1;
   logic [1:0]  n0, n1;
   int          passed = 0;
   int          total = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [7:0]  bytes[$];
   logic [31:0] last0 = 32'h0;
   logic [31:0] last1 = 32'h0;
   logic        wm = 1'b0;
   inport_loader #(.DEBOUNCE_CYCLES(D), .SIGN_EXTEND(0)) u0 (
      .clk(clk), .reset(reset), .sw_in(sw_in), .load_btn(load_btn), .word_mode(word_mode),
      .inport_data(d0), .inport_strobe(s0), .byte_count(n0), .collecting(c0)
   );
   inport_loader #(.DEBOUNCE_CYCLES(D), .SIGN_EXTEND(1)) u1 (
      .clk(clk), .reset(reset), .sw_in(sw_in), .load_btn(load_btn), .word_mode(word_mode),
      .inport_data(d1), .inport_strobe(s1), .byte_count(n1), .collecting(c1)
   );
   always #5 clk = ~clk;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask
   always @(negedge clk) begin
      if (!reset) begin
         if (s0) begin
            if (q0.size() == 0) check("strobe0_unexpected", {31'b0, s0}, 32'd0);
            else check("data0", d0, q0.pop_front());
         end
         if (s1) begin
            if (q1.size() == 0) check("strobe1_unexpected", {31'b0, s1}, 32'd0);
            else check("data1", d1, q1.pop_front());
         end
      end
   end
   task automatic publish(input logic [31:0] w0, input logic [31:0] w1);
      q0.push_back(w0);
      q1.push_back(w1);
      last0 = w0;
      last1 = w1;
   endtask
   task automatic model_press(input logic [7:0] b);
      if (!wm) publish(32'(b), 32'($signed(b)));
      else begin
         bytes.push_back(b);
         if (bytes.size() == 4) begin
            publish({bytes[0], bytes[1], bytes[2], bytes[3]}, {bytes[0], bytes[1], bytes[2], bytes[3]});
            bytes.delete();
         end
      end
   endtask
   task automatic quiet();
      @(negedge clk);
      check("pending0", 32'(q0.size()), 32'd0);
      check("pending1", 32'(q1.size()), 32'd0);
      check("hold0", d0, last0);
      check("hold1", d1, last1);
      check("byte_count", {30'b0, n0}, 32'(bytes.size()));
      check("collecting", {31'b0, c0}, 32'(bytes.size() != 0));
      check("byte_count1", {30'b0, n1}, 32'(bytes.size()));
   endtask
   task automatic press(input logic [7:0] b);
      sw_in = b;
      load_btn = 1'b1;
      model_press(b);
      repeat (D + 6 + $urandom_range(0, 4)) @(posedge clk);
      #1 load_btn = 1'b0;
      repeat (D + 6) @(posedge clk);
      #1 quiet();
   endtask
   task automatic set_mode(input logic m);
      if (m != wm && bytes.size() != 0) bytes.delete();
      wm = m;
      word_mode = m;
      repeat (6) @(posedge clk);
      #1 quiet();
   endtask
   task automatic bounce();
      for (int i = 0; i < 2; i++) begin
         load_btn = 1'b1;
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1 load_btn = 1'b0;
         repeat (2) @(posedge clk);
         #1;
      end
      repeat (D + 4) @(posedge clk);
      #1 quiet();
   endtask
   task automatic after_reset_check();
      bytes.delete();
      q0.delete();
      q1.delete();
      last0 = 32'h0;
      last1 = 32'h0;
      @(negedge clk);
      check("rst_data0", d0, 32'h0);
      check("rst_data1", d1, 32'h0);
      check("rst_strobe", {31'b0, s0 | s1}, 32'd0);
      check("rst_count", {30'b0, n0}, 32'd0);
      check("rst_collecting", {31'b0, c0}, 32'd0);
   endtask
   task automatic rst_pulse();
      reset = 1'b1;
      load_btn = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      after_reset_check();
      repeat (D + 6) @(posedge clk);
      #1;
   endtask
   task automatic reset_in_strobe_cycle(input logic [7:0] b);
      @(posedge clk);
      #1 sw_in = b;
      load_btn = 1'b1;
      repeat (D + 3) @(posedge clk);
      #1 reset = 1'b1;
      load_btn = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      after_reset_check();
      repeat (D + 6) @(posedge clk);
      #1 quiet();
   endtask
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_data", d0, 32'h0);
      check("reset_strobe", {31'b0, s0}, 32'd0);
      check("reset_count", {30'b0, n0}, 32'd0);
      check("reset_collecting", {31'b0, c0}, 32'd0);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      press(8'h88);
      press(8'h12);
      set_mode(1'b1);
      press(8'h12);
      press(8'h34);
      press(8'h56);
      press(8'h78);
      set_mode(1'b0);
      bounce();
      press(8'h3C);
      set_mode(1'b1);
      press(8'hAA);
      press(8'hBB);
      set_mode(1'b0);
      press(8'h01);
      set_mode(1'b1);
      press(8'hC1);
      press(8'hC2);
      rst_pulse();
      press(8'hC3);
      set_mode(1'b0);
      press(8'h77);
      reset_in_strobe_cycle(8'h5A);
      press(8'hF0);
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: press(8'($urandom_range(0, 255)));
            6, 7:             set_mode(~wm);
            8:                bounce();
            default:          rst_pulse();
         endcase
      end
      quiet();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
